// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: constants, the fetch
// state encoding and the {pc, inst} entry carried through the fetch queues.
package fetch_stage_pkg;

  // PC of the first fetch after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Codebase NOP (addi x0,x0,0), driven into decode on bubbles.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Generic enable/disable levels for control inputs.
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Maximum number of fetches in flight plus buffered instructions.
  localparam logic [2:0] FETCH_CREDITS = 3'd2;

  // Fetch state: RUN issues requests, HALTED waits for a redirect or reset.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // One queue entry: the PC of an instruction and the instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_queue.sv
// Two-entry FIFO of {pc, inst}. The head entry is always visible on pop_data;
// a pop on an empty queue and a push on a full queue without a pop are ignored.
// Flush empties the queue and wins over a push in the same cycle.
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rstd,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t pop_data,
  output logic [1:0]   count,
  output logic         empty
);

  fetch_entry_t mem_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;
  logic         pop_ok_s;
  logic         push_ok_s;

  // Qualify push/pop against occupancy; a full queue accepts a push only alongside a pop.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (pop && (count_r != 2'd0)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && ((count_r != 2'd2) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign empty    = (count_r == 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Holds the PC, issues requests to instruction memory
// under a two-credit budget, tags responses with their PC from an in-flight PC
// queue, buffers up to two returned instructions and feeds decode through the
// FD register. A response that arrives while the instruction queue is empty and
// decode is not stalled goes straight into FD, which sustains one instruction
// per cycle with single-cycle memory. Redirects discard old-path responses by
// counting them in drop_cnt.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        FD_valid,
  output logic [31:0] FD_pc,
  output logic [31:0] FD_inst
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_next_s;
  logic [1:0]   drop_cnt_r;
  logic [1:0]   drop_cnt_next_s;
  logic         fd_valid_r;
  logic         fd_valid_next_s;
  logic [31:0]  fd_pc_r;
  logic [31:0]  fd_pc_next_s;
  logic [31:0]  fd_inst_r;
  logic [31:0]  fd_inst_next_s;

  logic [1:0]   outstanding_s;
  logic [1:0]   outstanding_after_s;
  logic [2:0]   credits_used_s;
  logic         pcq_empty_s;
  fetch_entry_t pcq_push_entry_s;
  fetch_entry_t pcq_head_s;
  logic [1:0]   iq_count_s;
  logic         iq_empty_s;
  fetch_entry_t iq_head_s;
  fetch_entry_t rsp_entry_s;

  logic         req_s;
  logic         grant_s;
  logic         rsp_ok_s;
  logic         rsp_keep_s;
  logic         fd_load_s;
  logic         bypass_s;
  logic         iq_push_s;
  logic         iq_pop_s;

  // Request/response qualification and routing between queue, FD and bypass.
  always_comb begin
    credits_used_s = {1'b0, outstanding_s} + {1'b0, iq_count_s};
    if (!rstd && (state_r == RUN) && (credits_used_s < FETCH_CREDITS)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    grant_s    = req_s && imem_gnt;
    rsp_ok_s   = imem_rvalid && !pcq_empty_s;
    // Responses owed to an abandoned path, or arriving alongside a redirect, are discarded.
    rsp_keep_s = rsp_ok_s && (drop_cnt_r == 2'd0) && !redirect;
    fd_load_s  = !redirect && !stall;
    iq_pop_s   = fd_load_s && !iq_empty_s;
    bypass_s   = fd_load_s && iq_empty_s && rsp_keep_s;
    iq_push_s  = rsp_keep_s && !bypass_s;

    pcq_push_entry_s.pc   = word_align(pc_r);
    pcq_push_entry_s.inst = NOP_INST;
    rsp_entry_s           = pcq_head_s;
    rsp_entry_s.inst      = imem_rdata;

    outstanding_after_s = outstanding_s + {1'b0, grant_s} - {1'b0, rsp_ok_s};
  end

  // Next-state logic: halt parks the fetcher, a redirect always resumes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (redirect) begin
          state_next_s = RUN;
        end else if (halt) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = RUN;
        end
      end
      HALTED: begin
        if (redirect) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALTED;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // Next PC and drop count: a redirect owes every request still in flight after this cycle.
  always_comb begin
    pc_next_s       = pc_r;
    drop_cnt_next_s = drop_cnt_r;
    if (redirect) begin
      pc_next_s = word_align(redirect_pc);
    end else if (grant_s) begin
      pc_next_s = pc_r + 32'd4;
    end else begin
      pc_next_s = pc_r;
    end
    if (redirect) begin
      drop_cnt_next_s = outstanding_after_s;
    end else if (rsp_ok_s && (drop_cnt_r != 2'd0)) begin
      drop_cnt_next_s = drop_cnt_r - 2'd1;
    end else begin
      drop_cnt_next_s = drop_cnt_r;
    end
  end

  // Next FD contents: redirect forces a bubble, stall holds, else queue head, bypass or bubble.
  always_comb begin
    fd_valid_next_s = fd_valid_r;
    fd_pc_next_s    = fd_pc_r;
    fd_inst_next_s  = fd_inst_r;
    if (redirect) begin
      fd_valid_next_s = 1'b0;
      fd_pc_next_s    = 32'h0000_0000;
      fd_inst_next_s  = NOP_INST;
    end else if (stall) begin
      fd_valid_next_s = fd_valid_r;
      fd_pc_next_s    = fd_pc_r;
      fd_inst_next_s  = fd_inst_r;
    end else if (!iq_empty_s) begin
      fd_valid_next_s = 1'b1;
      fd_pc_next_s    = iq_head_s.pc;
      fd_inst_next_s  = iq_head_s.inst;
    end else if (bypass_s) begin
      fd_valid_next_s = 1'b1;
      fd_pc_next_s    = rsp_entry_s.pc;
      fd_inst_next_s  = rsp_entry_s.inst;
    end else begin
      fd_valid_next_s = 1'b0;
      fd_pc_next_s    = 32'h0000_0000;
      fd_inst_next_s  = NOP_INST;
    end
  end

  // Fetch state, PC and drop counter registers.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      drop_cnt_r <= 2'd0;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      drop_cnt_r <= drop_cnt_next_s;
    end
  end

  // FD pipeline register presented to decode.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      fd_valid_r <= 1'b0;
      fd_pc_r    <= 32'h0000_0000;
      fd_inst_r  <= NOP_INST;
    end else begin
      fd_valid_r <= fd_valid_next_s;
      fd_pc_r    <= fd_pc_next_s;
      fd_inst_r  <= fd_inst_next_s;
    end
  end

  // In-flight PC queue: one entry per granted request, retired by each response.
  fetch_queue u_pc_queue (
    .clk       (clk),
    .rstd      (rstd),
    .flush     (DISABLE),
    .push      (grant_s),
    .push_data (pcq_push_entry_s),
    .pop       (rsp_ok_s),
    .pop_data  (pcq_head_s),
    .count     (outstanding_s),
    .empty     (pcq_empty_s)
  );

  // Instruction queue holding returned words that decode could not take yet.
  fetch_queue u_inst_queue (
    .clk       (clk),
    .rstd      (rstd),
    .flush     (redirect),
    .push      (iq_push_s),
    .push_data (rsp_entry_s),
    .pop       (iq_pop_s),
    .pop_data  (iq_head_s),
    .count     (iq_count_s),
    .empty     (iq_empty_s)
  );

  assign imem_req  = req_s;
  assign imem_addr = word_align(pc_r);
  assign FD_valid  = fd_valid_r;
  assign FD_pc     = fd_pc_r;
  assign FD_inst   = fd_inst_r;

endmodule
